// File: rtl/qpsk_symbol_demod.sv
// QPSK symbol demodulator: square-wave I/Q mixing, integrate-and-dump per symbol, hard dibit decision.
// Optional differential dibit decoding is enabled by defining QPSK_DIFF_EN.
module qpsk_symbol_demod #(
  parameter int PHASE_BITS = 27,
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 32,
  parameter int SYM_W      = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [PHASE_BITS-1:0]    carrier_freq,
  input  logic signed [DATA_W-1:0] adc_data,
  input  logic                     adc_valid,
  input  logic [SYM_W-1:0]         sym_len,
  input  logic [ACC_W-1:0]         min_level,
  input  logic                     slip,
  output logic                     sym_valid,
  output logic [1:0]               sym_dibit,
  output logic signed [ACC_W-1:0]  sym_i,
  output logic signed [ACC_W-1:0]  sym_q,
  output logic                     carrier_ok,
  output logic                     sat
);

  localparam logic signed [ACC_W:0]   WIDE_POS = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   WIDE_NEG = -WIDE_POS;
  localparam logic signed [ACC_W-1:0] SAT_POS  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_NEG  = -SAT_POS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [PHASE_BITS-1:0]    phase;
  logic signed [ACC_W-1:0]  acc_i;
  logic signed [ACC_W-1:0]  acc_q;
  logic [SYM_W-1:0]         cnt;
  logic [SYM_W-1:0]         len_q;
  logic                     slip_pending;

  logic [1:0]               ref_quad;
  logic                     i_neg;
  logic                     q_neg;
  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [ACC_W:0]    sum_i_w;
  logic signed [ACC_W:0]    sum_q_w;
  logic signed [ACC_W-1:0]  sum_i;
  logic signed [ACC_W-1:0]  sum_q;
  logic                     ovf_i;
  logic                     ovf_q;

  logic                     active;
  logic                     accept;
  logic [SYM_W-1:0]         len_cur;
  logic                     last;
  logic                     dump;
  logic                     slip_next;
  logic                     sat_next;

  logic [ACC_W-1:0]         abs_i;
  logic [ACC_W-1:0]         abs_q;
  logic [ACC_W:0]           mag_w;
  logic [ACC_W-1:0]         mag;
  logic                     ok_next;
  logic [1:0]               dec_quad;
  logic [1:0]               dibit_next;

  // Symmetric clamp keeps |x| representable so the magnitude sum never needs the most-negative code.
  function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W:0] v);
    if (v > WIDE_POS)
      return SAT_POS;
    else if (v < WIDE_NEG)
      return SAT_NEG;
    else
      return v[ACC_W-1:0];
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en)  state_next = RUN;
      RUN:     if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ref_quad   = phase[PHASE_BITS-1 -: 2];
    i_neg      = ref_quad[1] ^ ref_quad[0];
    q_neg      = ref_quad[1];
    sample_ext = ACC_W'(adc_data);

    sum_i_w = i_neg ? ((ACC_W+1)'(acc_i) - (ACC_W+1)'(sample_ext))
                    : ((ACC_W+1)'(acc_i) + (ACC_W+1)'(sample_ext));
    sum_q_w = q_neg ? ((ACC_W+1)'(acc_q) - (ACC_W+1)'(sample_ext))
                    : ((ACC_W+1)'(acc_q) + (ACC_W+1)'(sample_ext));

    ovf_i = (sum_i_w > WIDE_POS) || (sum_i_w < WIDE_NEG);
    ovf_q = (sum_q_w > WIDE_POS) || (sum_q_w < WIDE_NEG);
    sum_i = clamp(sum_i_w);
    sum_q = clamp(sum_q_w);
  end

  // Symbol length is taken live while the counter sits at zero, then frozen for the rest of the symbol.
  always_comb begin
    active  = (state == RUN) && en;
    accept  = active && adc_valid && !slip_pending;
    len_cur = len_q;
    if (cnt == '0)
      len_cur = (sym_len < SYM_W'(2)) ? SYM_W'(2) : sym_len;
    last = (cnt == (len_cur - SYM_W'(1)));
    dump = accept && last;

    slip_next = 1'b0;
    if (active) begin
      if (slip_pending)
        slip_next = !adc_valid;
      else
        slip_next = slip;
    end

    sat_next = sat || (accept && (ovf_i || ovf_q));
  end

  always_comb begin
    abs_i    = sum_i[ACC_W-1] ? $unsigned(-sum_i) : $unsigned(sum_i);
    abs_q    = sum_q[ACC_W-1] ? $unsigned(-sum_q) : $unsigned(sum_q);
    mag_w    = {1'b0, abs_i} + {1'b0, abs_q};
    mag      = mag_w[ACC_W] ? {ACC_W{1'b1}} : mag_w[ACC_W-1:0];
    ok_next  = (mag >= min_level);
    dec_quad = {sum_q[ACC_W-1], sum_i[ACC_W-1] ^ sum_q[ACC_W-1]};
  end

`ifdef QPSK_DIFF_EN
  logic [1:0] prev_quad;

  always_ff @(posedge clk) begin
    if (rst)
      prev_quad <= 2'b00;
    else if ((state == IDLE) && (state_next == RUN))
      prev_quad <= 2'b00;
    else if (dump)
      prev_quad <= dec_quad;
  end

  always_comb begin
    dibit_next = dec_quad - prev_quad;
  end
`else
  always_comb begin
    dibit_next = dec_quad;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      acc_i        <= '0;
      acc_q        <= '0;
      cnt          <= '0;
      len_q        <= SYM_W'(2);
      slip_pending <= 1'b0;
      sym_valid    <= 1'b0;
      sym_dibit    <= 2'b00;
      sym_i        <= '0;
      sym_q        <= '0;
      carrier_ok   <= 1'b0;
      sat          <= 1'b0;
    end else begin
      state        <= state_next;
      phase        <= phase + carrier_freq;
      slip_pending <= slip_next;
      sat          <= sat_next;
      sym_valid    <= dump;

      if (cnt == '0)
        len_q <= len_cur;

      // Leaving RUN throws away the partial symbol; a dump reloads in the same clk so no sample is lost.
      if (!active) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else if (accept) begin
        if (last) begin
          acc_i <= '0;
          acc_q <= '0;
          cnt   <= '0;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt + SYM_W'(1);
        end
      end

      if (dump) begin
        sym_i      <= sum_i;
        sym_q      <= sum_q;
        sym_dibit  <= dibit_next;
        carrier_ok <= ok_next;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_demod.sv
// Directed bench for qpsk_symbol_demod: carrier patterns from a table, then hand sequences
// for enable drop, reset, slip, short symbols and saturation (a 16-bit integrator copy).
module tb_qpsk_symbol_demod;
  localparam int PB = 27;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int SW = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [PB-1:0]        carrier_freq;
  logic signed [DW-1:0] adc_data;
  logic                 adc_valid;
  logic [SW-1:0]        sym_len;
  logic [AW-1:0]        min_level;
  logic                 slip;

  logic                 sym_valid;
  logic [1:0]           sym_dibit;
  logic signed [AW-1:0] sym_i;
  logic signed [AW-1:0] sym_q;
  logic                 carrier_ok;
  logic                 sat;

  logic                 v16;
  logic [1:0]           d16;
  logic signed [15:0]   i16;
  logic signed [15:0]   q16;
  logic                 ok16;
  logic                 sat16;

  logic [PB-1:0]        tb_phase;

  int n_checks = 0;
  int n_fail   = 0;

  qpsk_symbol_demod #(.PHASE_BITS(PB), .DATA_W(DW), .ACC_W(AW), .SYM_W(SW)) dut (
    .clk(clk), .rst(rst), .en(en), .carrier_freq(carrier_freq),
    .adc_data(adc_data), .adc_valid(adc_valid), .sym_len(sym_len),
    .min_level(min_level), .slip(slip), .sym_valid(sym_valid),
    .sym_dibit(sym_dibit), .sym_i(sym_i), .sym_q(sym_q),
    .carrier_ok(carrier_ok), .sat(sat)
  );

  qpsk_symbol_demod #(.PHASE_BITS(PB), .DATA_W(DW), .ACC_W(16), .SYM_W(SW)) dut16 (
    .clk(clk), .rst(rst), .en(en), .carrier_freq(carrier_freq),
    .adc_data(adc_data), .adc_valid(adc_valid), .sym_len(sym_len),
    .min_level(min_level[15:0]), .slip(slip), .sym_valid(v16),
    .sym_dibit(d16), .sym_i(i16), .sym_q(q16),
    .carrier_ok(ok16), .sat(sat16)
  );

  always #5 clk = ~clk;

  // Bench-side phase copy used only to shape the stimulus.
  always @(posedge clk) begin
    if (rst) tb_phase <= '0;
    else     tb_phase <= tb_phase + carrier_freq;
  end

  typedef struct {
    int          pattern;
    int          exp_clks;
    longint      exp_i;
    longint      exp_q;
    logic [1:0]  exp_dibit;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // 0:+1000*Iref 1:-1000*Iref 2:-1000*Qref 3:-500*(Iref+Qref) 4:zero
  function automatic logic signed [DW-1:0] patternSample(input int p, input logic [PB-1:0] ph);
    logic [1:0] qd;
    int iref;
    int qref;
    int v;
    qd   = ph[PB-1 -: 2];
    iref = (qd == 2'd0 || qd == 2'd3) ? 1 : -1;
    qref = (qd == 2'd0 || qd == 2'd1) ? 1 : -1;
    case (p)
      0:       v = 1000 * iref;
      1:       v = -1000 * iref;
      2:       v = -1000 * qref;
      3:       v = -500 * (iref + qref);
      default: v = 0;
    endcase
    return DW'(v);
  endfunction

  // Drives a pattern each clk until a sym_valid is seen or the budget runs out.
  task automatic applyStimulus(input int pattern, input int max_clks, output bit found, output int clks);
    found = 1'b0;
    clks  = 0;
    for (int k = 1; k <= max_clks; k++) begin
      adc_data = patternSample(pattern, tb_phase);
      @(negedge clk);
      if (sym_valid) begin
        found = 1'b1;
        clks  = k;
        break;
      end
    end
  endtask

  task automatic sendSample(input int value, input bit sl);
    adc_valid = 1'b1;
    adc_data  = DW'(value);
    slip      = sl;
    @(negedge clk);
    adc_valid = 1'b0;
    slip      = 1'b0;
  endtask

  task automatic idleClk(input bit sl);
    slip = sl;
    @(negedge clk);
    slip = 1'b0;
  endtask

  initial begin
    bit found;
    int clks;
    int stray;

    vecs[0] = '{pattern: 0, exp_clks: 65, exp_i:  64000, exp_q:      0, exp_dibit: 2'b00, exp_ok: 1'b1};
    vecs[1] = '{pattern: 1, exp_clks: 64, exp_i: -64000, exp_q:      0, exp_dibit: 2'b01, exp_ok: 1'b1};
    vecs[2] = '{pattern: 2, exp_clks: 64, exp_i:      0, exp_q: -64000, exp_dibit: 2'b11, exp_ok: 1'b1};
    vecs[3] = '{pattern: 3, exp_clks: 64, exp_i: -32000, exp_q: -32000, exp_dibit: 2'b10, exp_ok: 1'b1};
    vecs[4] = '{pattern: 4, exp_clks: 64, exp_i:      0, exp_q:      0, exp_dibit: 2'b00, exp_ok: 1'b0};

    rst = 1'b1; en = 1'b0; adc_valid = 1'b0; slip = 1'b0;
    carrier_freq = '0; adc_data = '0; sym_len = SW'(64); min_level = AW'(1000);
    repeat (3) @(negedge clk);
    checkOutput("reset_sym_valid", sym_valid, 0);
    checkOutput("reset_sym_i", sym_i, 0);
    checkOutput("reset_carrier_ok", carrier_ok, 0);
    checkOutput("reset_sat", sat, 0);
    rst = 1'b0;
    @(negedge clk);

    carrier_freq = PB'(1 << 23);
    en = 1'b1;
    adc_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      applyStimulus(vecs[n].pattern, 200, found, clks);
      checkOutput($sformatf("vec%0d_found", n), found, 1);
      if (found) begin
        checkOutput($sformatf("vec%0d_interval", n), clks, vecs[n].exp_clks);
        checkOutput($sformatf("vec%0d_sym_i", n), sym_i, vecs[n].exp_i);
        checkOutput($sformatf("vec%0d_sym_q", n), sym_q, vecs[n].exp_q);
        checkOutput($sformatf("vec%0d_dibit", n), sym_dibit, vecs[n].exp_dibit);
        checkOutput($sformatf("vec%0d_carrier_ok", n), carrier_ok, vecs[n].exp_ok);
      end
    end

    // Enable drop at cnt=30: partial symbol discarded, next symbol starts from zero.
    stray = 0;
    for (int k = 0; k < 30; k++) begin
      adc_data = patternSample(0, tb_phase);
      @(negedge clk);
      if (sym_valid) stray++;
    end
    en = 1'b0;
    @(negedge clk);
    if (sym_valid) stray++;
    en = 1'b1;
    applyStimulus(0, 200, found, clks);
    checkOutput("endrop_no_stray_valid", stray, 0);
    checkOutput("endrop_found", found, 1);
    if (found) begin
      checkOutput("endrop_interval", clks, 65);
      checkOutput("endrop_sym_i", sym_i, 64000);
      checkOutput("endrop_sym_q", sym_q, 0);
    end

    // Reset mid-symbol.
    for (int k = 0; k < 20; k++) begin
      adc_data = patternSample(0, tb_phase);
      @(negedge clk);
    end
    rst = 1'b1; en = 1'b0; adc_valid = 1'b0; carrier_freq = '0;
    @(negedge clk);
    checkOutput("midrst_sym_valid", sym_valid, 0);
    checkOutput("midrst_sym_dibit", sym_dibit, 0);
    checkOutput("midrst_sym_i", sym_i, 0);
    checkOutput("midrst_sym_q", sym_q, 0);
    checkOutput("midrst_carrier_ok", carrier_ok, 0);
    rst = 1'b0;
    sym_len = SW'(4);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);

    // Slip on idle clks; a second slip while pending must not drop another sample.
    idleClk(1'b1);
    idleClk(1'b1);
    sendSample(1, 1'b0);
    sendSample(2, 1'b0);
    sendSample(4, 1'b0);
    sendSample(8, 1'b0);
    checkOutput("slipA_no_early_valid", sym_valid, 0);
    sendSample(16, 1'b0);
    checkOutput("slipA_valid", sym_valid, 1);
    checkOutput("slipA_sym_i", sym_i, 30);
    checkOutput("slipA_sym_q", sym_q, 30);
    checkOutput("slipA_dibit", sym_dibit, 0);
    checkOutput("slipA_carrier_ok", carrier_ok, 0);

    // Slip coincident with a sample drops the following sample instead.
    sendSample(10, 1'b0);
    sendSample(20, 1'b1);
    sendSample(40, 1'b0);
    sendSample(80, 1'b0);
    sendSample(160, 1'b0);
    checkOutput("slipB_valid", sym_valid, 1);
    checkOutput("slipB_sym_i", sym_i, 270);

    // sym_len=1 behaves as 2.
    sym_len = SW'(1);
    sendSample(5, 1'b0);
    checkOutput("len1_no_valid_first", sym_valid, 0);
    idleClk(1'b0);
    sendSample(6, 1'b0);
    checkOutput("len1_valid", sym_valid, 1);
    checkOutput("len1_sym_i", sym_i, 11);
    idleClk(1'b0);
    checkOutput("len1_strobe_width", sym_valid, 0);
    checkOutput("len1_hold_sym_i", sym_i, 11);
    sendSample(7, 1'b0);
    sendSample(9, 1'b0);
    checkOutput("len1_second_valid", sym_valid, 1);
    checkOutput("len1_second_sym_i", sym_i, 16);

    // Saturation on the 16-bit integrator copy, constant phase (quadrant 0).
    sym_len = SW'(4);
    checkOutput("sat16_clear_before", sat16, 0);
    for (int k = 0; k < 4; k++) sendSample(32767, 1'b0);
    checkOutput("sat_main_valid", sym_valid, 1);
    checkOutput("sat_main_sym_i", sym_i, 131068);
    checkOutput("sat_main_sym_q", sym_q, 131068);
    checkOutput("sat_main_flag", sat, 0);
    checkOutput("sat_main_carrier_ok", carrier_ok, 1);
    checkOutput("sat16_valid", v16, 1);
    checkOutput("sat16_sym_i", i16, 32767);
    checkOutput("sat16_sym_q", q16, 32767);
    checkOutput("sat16_flag", sat16, 1);
    checkOutput("sat16_carrier_ok", ok16, 1);
    for (int k = 0; k < 4; k++) sendSample(1, 1'b0);
    checkOutput("sat16_small_sym_i", i16, 4);
    checkOutput("sat16_sticky", sat16, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
